// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Purpose : constants, FSM state encoding and result payload shared by the
//           RS-232 receiver and its companion transmitter.
// Ports   : none (package).
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_TICK   = 7;
  localparam int unsigned LAST_TICK  = 15;
  localparam int unsigned NBITS_MIN  = 5;
  localparam int unsigned NBITS_MAX  = 8;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned NBITS_W    = 4;
  localparam int unsigned BIT_CNT_W  = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } uart_state_e;

  // Completed-frame payload: word plus stop-bit status
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              frame_err;
  } uart_rx_result_t;

  // Force the frame width into the supported 5..8 range
  function automatic logic [NBITS_W-1:0] clamp_nbits(input logic [NBITS_W-1:0] n);
    logic [NBITS_W-1:0] r;
    r = n;
    if (n < NBITS_W'(NBITS_MIN)) r = NBITS_W'(NBITS_MIN);
    if (n > NBITS_W'(NBITS_MAX)) r = NBITS_W'(NBITS_MAX);
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// ----------------------------------------------------------------------------
// uart_rx_sync
// Purpose : metastability synchroniser for the raw serial line.
// Ports   : Clk  - system clock
//           Rst  - asynchronous active-high reset (chain resets to idle-high)
//           Rx   - raw asynchronous serial input
//           rx_s - synchronised serial line, SYNC_STAGES Clk of latency
// ----------------------------------------------------------------------------
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Rx,
  output logic rx_s
);

  logic [SYNC_STAGES-1:0] r_sync;

  // Reset to 1 so a reset never looks like a start bit
  generate
    if (SYNC_STAGES == 1) begin : g_single
      always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) r_sync <= '1;
        else     r_sync <= Rx;
      end
    end else begin : g_chain
      always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) r_sync <= '1;
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], Rx};
      end
    end
  endgenerate

  assign rx_s = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rs232_rx.sv
// ----------------------------------------------------------------------------
// uart_rs232_rx
// Purpose : 16x-oversampling RS-232 receiver. Recovers start/data/stop
//           framing, delivers a right-justified word with a one-cycle done
//           strobe and a framing-error flag. Tick is a clock enable only.
// Ports   : Clk      - system clock
//           Rst      - asynchronous active-high reset
//           Tick     - one-Clk pulse at 16x baud
//           RxEn     - arms start-bit detection (only gates IDLE->START)
//           NBits    - data bits per frame, clamped to 5..8 at frame start
//           Rx       - raw serial line, idles high
//           RxData   - last received word, upper unused bits zero
//           RxDone   - one-Clk pulse when a frame completes
//           FrameErr - 1 when the last frame's stop bit sampled low
//           Busy     - 1 whenever the receiver is not idle
// ----------------------------------------------------------------------------
module uart_rs232_rx #(
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          Tick,
  input  logic                          RxEn,
  input  logic [uart_pkg::NBITS_W-1:0]  NBits,
  input  logic                          Rx,
  output logic [uart_pkg::DATA_W-1:0]   RxData,
  output logic                          RxDone,
  output logic                          FrameErr,
  output logic                          Busy
);

  import uart_pkg::*;

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);

  uart_state_e          r_state;
  logic [TICK_W-1:0]    r_tick_cnt;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [NBITS_W-1:0]   r_nbits;
  logic [DATA_W-1:0]    r_shift;
  uart_rx_result_t      r_result;
  logic                 r_done;
  logic                 r_busy;

  logic                 w_rx_s;
  logic                 w_mid_tick;
  logic                 w_last_tick;
  logic                 w_last_bit;
  logic [DATA_W-1:0]    w_word;

  uart_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .Clk  (Clk),
    .Rst  (Rst),
    .Rx   (Rx),
    .rx_s (w_rx_s)
  );

  // Sample points: middle of the start bit, middle of data/stop bits
  assign w_mid_tick  = Tick && (r_tick_cnt == TICK_W'(MID_TICK));
  assign w_last_tick = Tick && (r_tick_cnt == TICK_W'(LAST_TICK));
  assign w_last_bit  = (r_bit_cnt == BIT_CNT_W'(r_nbits - NBITS_W'(1)));

  // Bits enter at the MSB, so after NBits samples the word sits in the top
  // of the register; shifting down right-aligns it and zero-fills the rest.
  assign w_word = r_shift >> (NBITS_W'(DATA_W) - r_nbits);

  // Receiver FSM, counters, shift register and registered outputs
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state    <= ST_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_nbits    <= NBITS_W'(NBITS_MAX);
      r_shift    <= '0;
      r_result   <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Tick && RxEn && !w_rx_s) begin
            r_state    <= ST_START;
            r_busy     <= 1'b1;
            r_tick_cnt <= '0;
            r_nbits    <= clamp_nbits(NBits);
          end
        end

        ST_START: begin
          if (w_mid_tick) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            if (w_rx_s) begin
              // Line back high at mid start bit: glitch, not a frame
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_DATA;
            end
          end else if (Tick) begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
          end
        end

        ST_DATA: begin
          if (w_last_tick) begin
            r_shift    <= {w_rx_s, r_shift[DATA_W-1:1]};
            r_tick_cnt <= '0;
            if (w_last_bit) r_state   <= ST_STOP;
            else            r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
          end else if (Tick) begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
          end
        end

        ST_STOP: begin
          if (w_last_tick) begin
            r_done             <= 1'b1;
            r_result.data      <= w_word;
            r_result.frame_err <= !w_rx_s;
            r_tick_cnt         <= '0;
            if (w_rx_s) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_WAIT_HIGH;
            end
          end else if (Tick) begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
          end
        end

        // Break / framing error: wait for the line to recover before rearming
        ST_WAIT_HIGH: begin
          if (w_rx_s) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign RxData   = r_result.data;
  assign FrameErr = r_result.frame_err;
  assign RxDone   = r_done;
  assign Busy     = r_busy;

endmodule

// File: tb/tb_uart_rs232_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rs232_rx
// Purpose : self-checking bench for uart_rs232_rx. Drives serial frames
//           bit-by-bit in Tick units and compares every completed frame
//           against an arithmetic reference of the framing rules.
// ----------------------------------------------------------------------------
module tb_uart_rs232_rx;

  localparam int unsigned TICK_DIV = 4;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Tick;
  logic       RxEn;
  logic [3:0] NBits;
  logic       Rx;
  logic [7:0] RxData;
  logic       RxDone;
  logic       FrameErr;
  logic       Busy;

  int n_cmp = 0;
  int n_err = 0;

  int         done_cnt = 0;
  int         exp_done = 0;
  logic [8:0] obs_q[$];
  logic [7:0] last_exp = 8'h00;

  logic prev_done = 1'b0;
  logic prev_ferr = 1'b0;
  logic watch_busy = 1'b0;
  logic busy_seen  = 1'b0;

  uart_rs232_rx #(
    .OVERSAMPLE  (16),
    .SYNC_STAGES (2)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Tick     (Tick),
    .RxEn     (RxEn),
    .NBits    (NBits),
    .Rx       (Rx),
    .RxData   (RxData),
    .RxDone   (RxDone),
    .FrameErr (FrameErr),
    .Busy     (Busy)
  );

  always #5 Clk = ~Clk;

  // Baud tick: one Clk wide every TICK_DIV cycles, changed on the falling edge
  initial begin
    int k;
    k    = 0;
    Tick = 1'b0;
    forever begin
      @(negedge Clk);
      k    = (k + 1) % TICK_DIV;
      Tick = (k == 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: collect every completed frame, sampled on the falling edge
  always @(negedge Clk) begin
    if (prev_done && !prev_ferr) check("busy_after_done", 32'(Busy), 32'd0);
    if (RxDone) begin
      done_cnt++;
      obs_q.push_back({FrameErr, RxData});
    end
    if (watch_busy && Busy) busy_seen = 1'b1;
    prev_done = RxDone;
    prev_ferr = FrameErr;
  end

  // Reference: effective frame width
  function automatic int eff_nbits(input int n);
    if (n < 5) return 5;
    if (n > 8) return 8;
    return n;
  endfunction

  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge Clk);
      if (Tick) k++;
    end
  endtask

  task automatic line_bit(input logic b, input int ticks);
    #1 Rx = b;
    wait_ticks(ticks);
  endtask

  // Serial frame: start, nb data bits LSB first, stop held for stop_ticks
  task automatic send_frame(input logic [7:0] data, input int nb, input logic stop_val,
                            input int stop_ticks, input bit scramble);
    line_bit(1'b0, 16);
    for (int i = 0; i < nb; i++) begin
      line_bit(data[i], 16);
      if (scramble && i == 1) begin
        #2;
        NBits = 4'($urandom_range(0, 15));
        RxEn  = 1'($urandom_range(0, 1));
      end
    end
    line_bit(stop_val, stop_ticks);
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] data, input int nb_raw,
                              input logic stop_val);
    logic [8:0] got;
    logic [7:0] exp_data;
    int         eff;
    eff      = eff_nbits(nb_raw);
    exp_data = 8'(int'(data) % (1 << eff));
    exp_done++;
    last_exp = exp_data;
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'(exp_done));
    check({tag, "_qsize"}, 32'(obs_q.size()), 32'd1);
    if (obs_q.size() != 0) begin
      got = obs_q.pop_front();
      check({tag, "_data"}, 32'(got[7:0]), 32'(exp_data));
      check({tag, "_ferr"}, 32'(got[8]), 32'(!stop_val));
    end
  endtask

  task automatic good_frame(input string tag, input logic [7:0] data, input int nb_raw);
    NBits = 4'(nb_raw);
    send_frame(data, eff_nbits(nb_raw), 1'b1, 16, 1'b0);
    expect_frame(tag, data, nb_raw, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int         nb;
    logic       stop_ok;
    logic [7:0] lb [3];

    Rst   = 1'b1;
    RxEn  = 1'b0;
    NBits = 4'd8;
    Rx    = 1'b1;
    repeat (3) @(negedge Clk);
    check("rst_rxdata", 32'(RxData), 32'h0);
    check("rst_rxdone", 32'(RxDone), 32'h0);
    check("rst_ferr", 32'(FrameErr), 32'h0);
    check("rst_busy", 32'(Busy), 32'h0);
    Rst  = 1'b0;
    RxEn = 1'b1;
    wait_ticks(4);

    // 8N1 back-to-back
    good_frame("b55", 8'h55, 8);
    good_frame("bA3", 8'hA3, 8);
    #2 check("idle_busy", 32'(Busy), 32'h0);

    // Short frames and clamping of NBits below the range
    good_frame("n5", 8'h0D, 5);
    good_frame("n3", 8'hF6, 3);
    good_frame("n12", 8'hC9, 12);

    // Glitch shorter than half a bit
    line_bit(1'b0, 4);
    #1 Rx = 1'b1;
    wait_ticks(2);
    #2 check("glitch_busy_hi", 32'(Busy), 32'h1);
    wait_ticks(8);
    #2 check("glitch_busy_lo", 32'(Busy), 32'h0);
    check("glitch_no_done", 32'(done_cnt), 32'(exp_done));
    check("glitch_rxdata", 32'(RxData), 32'(last_exp));

    // Framing error with a long low stop, then recovery
    NBits = 4'd8;
    send_frame(8'h3C, 8, 1'b0, 40, 1'b0);
    #2 check("ferr_wait_busy", 32'(Busy), 32'h1);
    line_bit(1'b1, 16);
    #2 check("ferr_recovered_busy", 32'(Busy), 32'h0);
    expect_frame("f3C", 8'h3C, 8, 1'b0);
    good_frame("b81", 8'h81, 8);

    // Reset in the middle of data bit 4
    NBits = 4'd8;
    line_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) line_bit(1'b1, 16);
    line_bit(1'b0, 8);
    #2 Rst = 1'b1;
    #1;
    check("mrst_rxdata", 32'(RxData), 32'h0);
    check("mrst_rxdone", 32'(RxDone), 32'h0);
    check("mrst_ferr", 32'(FrameErr), 32'h0);
    check("mrst_busy", 32'(Busy), 32'h0);
    Rx = 1'b1;
    repeat (5) @(negedge Clk);
    Rst = 1'b0;
    last_exp = 8'h00;
    wait_ticks(40);
    check("mrst_no_done", 32'(done_cnt), 32'(exp_done));

    // RxEn low while the line toggles
    RxEn       = 1'b0;
    watch_busy = 1'b1;
    for (int i = 0; i < 40; i++) line_bit(1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
    line_bit(1'b1, 20);
    watch_busy = 1'b0;
    check("rxen_off_busy", 32'(busy_seen), 32'h0);
    check("rxen_off_done", 32'(done_cnt), 32'(exp_done));
    check("rxen_off_rxdata", 32'(RxData), 32'(last_exp));
    #2 RxEn = 1'b1;

    // Loopback-style byte set
    lb[0] = 8'h00;
    lb[1] = 8'hFF;
    lb[2] = 8'h5A;
    for (int i = 0; i < 3; i++) good_frame($sformatf("lb%0d", i), lb[i], 8);

    // Randomized frames, NBits/RxEn disturbed mid-frame
    for (int f = 0; f < 24; f++) begin
      #2;
      RxEn    = 1'b1;
      nb      = int'($urandom_range(0, 15));
      NBits   = 4'(nb);
      d       = 8'($urandom);
      stop_ok = ($urandom_range(0, 5) != 0);
      send_frame(d, eff_nbits(nb), stop_ok, stop_ok ? 16 : 40, 1'b1);
      if (!stop_ok) begin
        #2 check($sformatf("r%0d_wait_busy", f), 32'(Busy), 32'h1);
        line_bit(1'b1, 16);
      end
      #2 check($sformatf("r%0d_idle_busy", f), 32'(Busy), 32'h0);
      expect_frame($sformatf("r%0d", f), d, nb, stop_ok);
    end

    wait_ticks(4);
    check("final_queue_empty", 32'(obs_q.size()), 32'd0);
    check("final_done_cnt", 32'(done_cnt), 32'(exp_done));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
